non_linear_counter: RTL and testbench
=====================================

NON_LINEAR_COUNTER -- requirements
Module: non_linear_counter

Interface
REQ-001 Parameter: SEQ_LEN, 8, number of states in the count sequence; fixed at 8, and any other value SHALL be a compile-time error.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; low clears the block immediately, independent of clk.
REQ-004 Port: count  output  3  current counter value in the fixed non-linear sequence; registered.
REQ-005 Port: phase  output  3  position index (0..7) of count within the sequence; registered.
REQ-006 Port: wrap  output  1  registered one-cycle pulse, high in the cycle after count returns from 3'b010 to 3'b000.
REQ-007 Ports clk, reset and count SHALL keep exactly these names and widths; phase and wrap MAY be left unconnected by an instantiating module.

Function
REQ-008 The sequence SHALL advance one step on every rising clk edge while reset is high; there is no enable and no hold.
REQ-009 The count sequence SHALL be 000 -> 001 -> 011 -> 111 -> 110 -> 100 -> 101 -> 010 -> 000, repeating, with period 8 cycles.
REQ-010 phase SHALL equal 0,1,2,...,7 for the eight sequence values in REQ-009 order and SHALL always match count (phase = index of count).
REQ-011 Next-state logic SHALL be a pure combinational mapping from the current count to the next count, not count+1 arithmetic.
REQ-012 Every 3-bit value is a legal state, so no lock-up state exists.
REQ-013 If the register is nevertheless found inconsistent (phase not matching count, e.g. after an upset), the next edge SHALL load count=000 and phase=0.
REQ-014 wrap SHALL be 1 for exactly the one cycle in which count=000 has been reached from 010.
REQ-015 wrap SHALL be 0 when count=000 is produced by reset.
REQ-016 Latency: a change on count is visible after the same clk edge that causes it; there is zero added pipeline.
REQ-017 All outputs SHALL be driven directly from flops; count, phase and wrap SHALL have no combinational path from any input.

Reset
REQ-018 While reset=0: count=000, phase=0, wrap=0, asserted asynchronously without waiting for a clk edge.
REQ-019 On release (reset 0->1), the first rising clk edge with reset=1 SHALL move count to 001.
REQ-020 Reset asserted mid-sequence SHALL abort the sequence immediately, and counting SHALL restart from 000 after release.
REQ-021 Reset release SHALL be synchronised by the integrating design; this block only requires reset to meet recovery/removal timing relative to clk.

Structure
REQ-022 Shared package nlc_pkg SHALL hold SEQ_LEN, the eight sequence constants (S0=000 ... S7=010) and the reset value.
REQ-023 One combinational sub-module, nlc_next_state, SHALL map count to next count, next phase and the wrap condition.
REQ-024 The top level SHALL contain only the registers, the reset logic and the consistency check.

Verification
REQ-025 Hold reset=0 for 50 time units while clk toggles (period 10) -> count=000, phase=0 and wrap=0 throughout.
REQ-026 Release reset, run 16 edges -> count follows 001,011,111,110,100,101,010,000 twice and phase follows 1..7,0 twice.
REQ-027 Sequence wraps 010->000 -> wrap=1 for exactly that one cycle and 0 on all other cycles.
REQ-028 Assert reset=0 between clk edges while count=111 -> count=000 immediately, before the next clk edge.
REQ-029 After the mid-sequence reset, release it -> the next edge gives count=001.
REQ-030 Force the register inconsistent (count=111, phase=0) -> the next edge gives count=000, phase=0, wrap=0.

Source files
------------

// File: rtl/nlc_pkg.sv
// rtl/nlc_pkg.sv - shared constants and sequence lookup for the non-linear counter
package nlc_pkg;

    localparam int SEQ_LEN = 8;

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b011;
    localparam logic [2:0] S3 = 3'b111;
    localparam logic [2:0] S4 = 3'b110;
    localparam logic [2:0] S5 = 3'b100;
    localparam logic [2:0] S6 = 3'b101;
    localparam logic [2:0] S7 = 3'b010;

    localparam logic [2:0] RESET_COUNT = S0;
    localparam logic [2:0] RESET_PHASE = 3'd0;

    // Sequence value expected at a given position; used to check count/phase agreement
    function automatic logic [2:0] seq_value(input logic [2:0] idx);
        logic [2:0] v;
        case (idx)
            3'd0:    v = S0;
            3'd1:    v = S1;
            3'd2:    v = S2;
            3'd3:    v = S3;
            3'd4:    v = S4;
            3'd5:    v = S5;
            3'd6:    v = S6;
            default: v = S7;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/non_linear_counter_if.sv
// rtl/non_linear_counter_if.sv - current-state / next-state bundle between register and mapping logic
interface nlc_if;
    logic [2:0] count;
    logic [2:0] next_count;
    logic [2:0] next_phase;
    logic       next_wrap;

    modport master (output count, input next_count, next_phase, next_wrap);
    modport slave  (input count, output next_count, next_phase, next_wrap);
endinterface

// File: rtl/nlc_next_state.sv
// rtl/nlc_next_state.sv - combinational count -> next count/phase/wrap mapping
module nlc_next_state
    import nlc_pkg::*;
(
    nlc_if.slave ns
);

    // Table lookup on the current count; wrap flags the S7 -> S0 step
    always_comb begin
        ns.next_count = RESET_COUNT;
        ns.next_phase = RESET_PHASE;
        ns.next_wrap  = 1'b0;
        case (ns.count)
            S0: begin ns.next_count = S1; ns.next_phase = 3'd1; end
            S1: begin ns.next_count = S2; ns.next_phase = 3'd2; end
            S2: begin ns.next_count = S3; ns.next_phase = 3'd3; end
            S3: begin ns.next_count = S4; ns.next_phase = 3'd4; end
            S4: begin ns.next_count = S5; ns.next_phase = 3'd5; end
            S5: begin ns.next_count = S6; ns.next_phase = 3'd6; end
            S6: begin ns.next_count = S7; ns.next_phase = 3'd7; end
            S7: begin ns.next_count = S0; ns.next_phase = 3'd0; ns.next_wrap = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/non_linear_counter.sv
// rtl/non_linear_counter.sv - 8-state non-linear counter with phase index and wrap pulse
module non_linear_counter #(
    parameter int SEQ_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] count,
    output logic [2:0] phase,
    output logic       wrap
);

    import nlc_pkg::*;

    // The sequence table is hard-wired to eight entries
    if (SEQ_LEN != nlc_pkg::SEQ_LEN) begin : g_bad_seq_len
        $error("non_linear_counter: SEQ_LEN must be 8");
    end

    nlc_if ns_bus ();

    assign ns_bus.count = count;

    nlc_next_state u_next_state (
        .ns (ns_bus)
    );

    // phase must point at the table entry that equals count; anything else is an upset
    logic consistent;
    assign consistent = (seq_value(phase) == count);

    // State register: async clear, resynchronise to S0 on inconsistency, otherwise step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RESET_COUNT;
            phase <= RESET_PHASE;
            wrap  <= 1'b0;
        end else if (!consistent) begin
            count <= RESET_COUNT;
            phase <= RESET_PHASE;
            wrap  <= 1'b0;
        end else begin
            count <= ns_bus.next_count;
            phase <= ns_bus.next_phase;
            wrap  <= ns_bus.next_wrap;
        end
    end

endmodule

// File: tb/tb_non_linear_counter.sv
// tb/tb_non_linear_counter.sv - scoreboard bench for non_linear_counter
module tb_non_linear_counter;

    typedef struct packed {
        logic [2:0] c;
        logic [2:0] p;
        logic       w;
    } exp_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    int   model_phase;
    exp_t exp_q[$];
    exp_t e;

    nlc_if mon ();

    non_linear_counter #(.SEQ_LEN(8)) dut (
        .clk   (clk),
        .reset (reset),
        .count (mon.count),
        .phase (mon.next_phase),
        .wrap  (mon.next_wrap)
    );

    assign mon.next_count = 3'b000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ref_seq(input int idx);
        logic [2:0] v;
        case (idx)
            0: v = 3'b000;
            1: v = 3'b001;
            2: v = 3'b011;
            3: v = 3'b111;
            4: v = 3'b110;
            5: v = 3'b100;
            6: v = 3'b101;
            default: v = 3'b010;
        endcase
        return v;
    endfunction

    task automatic push_steps(input int n);
        for (int i = 0; i < n; i++) begin
            model_phase = (model_phase + 1) % 8;
            exp_q.push_back('{c: ref_seq(model_phase), p: 3'(model_phase), w: (model_phase == 0)});
        end
    endtask

    task automatic drain_queue(input string tag);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if ({mon.count, mon.next_phase, mon.next_wrap} !== {e.c, e.p, e.w}) begin
                tests_failed++;
                $display("FAIL %s: count=%b phase=%0d wrap=%b expected count=%b phase=%0d wrap=%b",
                         tag, mon.count, mon.next_phase, mon.next_wrap, e.c, e.p, e.w);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({mon.count, mon.next_phase, mon.next_wrap} !== 7'b0) begin
                tests_failed++;
                $display("FAIL reset_hold: count=%b phase=%0d wrap=%b expected 000/0/0",
                         mon.count, mon.next_phase, mon.next_wrap);
            end
            #5;
        end
    endtask

    task automatic test_sequence();
        @(negedge clk);
        reset = 1'b1;
        model_phase = 0;
        push_steps(16);
        drain_queue("sequence");
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (mon.count === 3'b111) found = 1'b1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL mid_reset_find: count=%b never reached expected 111", mon.count);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({mon.count, mon.next_phase, mon.next_wrap} !== 7'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: count=%b phase=%0d wrap=%b expected 000/0/0",
                     mon.count, mon.next_phase, mon.next_wrap);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (mon.count !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_reset_hold: count=%b expected 000", mon.count);
        end
        @(negedge clk);
        reset = 1'b1;
        model_phase = 0;
        push_steps(9);
        drain_queue("after_mid_reset");
    endtask

    task automatic test_inconsistent();
        @(negedge clk);
        force dut.count = 3'b111;
        force dut.phase = 3'b000;
        #1;
        release dut.count;
        release dut.phase;
        #1;
        tests_run++;
        if ({mon.count, mon.next_phase} !== {3'b111, 3'b000}) begin
            tests_failed++;
            $display("FAIL upset_inject: count=%b phase=%0d expected 111/0", mon.count, mon.next_phase);
        end
        exp_q.push_back('{c: 3'b000, p: 3'd0, w: 1'b0});
        model_phase = 0;
        push_steps(3);
        drain_queue("upset_recover");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({mon.count, mon.next_phase, mon.next_wrap} !== 7'b0) begin
            tests_failed++;
            $display("FAIL pulse_reset: count=%b phase=%0d wrap=%b expected 000/0/0",
                     mon.count, mon.next_phase, mon.next_wrap);
        end
        model_phase = 0;
        push_steps(10);
        drain_queue("after_pulse");
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        model_phase = 0;
        test_reset();
        test_sequence();
        test_mid_reset();
        test_inconsistent();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
